// File: rtl/hazard_forward_unit.sv
// Operand bypass selects and front-end stall for a 5-stage pipeline with a multi-cycle multiplier.
// fwd_sel and stall are combinational. The multiply tracker and stall counter update on each clock edge.
module hazard_forward_unit #(
  parameter int NUM_SRC  = 2,
  parameter int MULT_LAT = 3,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [5*NUM_SRC-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]     id_rs_used,
  input  logic                   id_is_mult,
  input  logic [5*NUM_SRC-1:0]   ex_rs,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_memread,
  input  logic                   ex_mult_issue,
  input  logic [4:0]             exmem_rd,
  input  logic                   exmem_regwrite,
  input  logic [4:0]             memwb_rd,
  input  logic                   memwb_regwrite,
  output logic [2*NUM_SRC-1:0]   fwd_sel,
  output logic                   stall,
  output logic                   mult_busy,
  output logic                   mult_done,
  output logic [4:0]             mult_rd,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int CW = $clog2(MULT_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(MULT_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       mult_rd_q, mult_rd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mult_long;

  // A new multiply is accepted when idle or on the final busy cycle (back-to-back).
  always_comb begin
    cnt_d     = cnt_q;
    mult_rd_d = mult_rd_q;
    if (ex_mult_issue && (cnt_q <= ONE)) begin
      cnt_d     = LAT;
      mult_rd_d = ex_rd;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  assign mult_busy = (cnt_q != '0);
  assign mult_done = (cnt_q == ONE);
  assign mult_rd   = mult_rd_q;
  assign mult_long = (cnt_q > ONE);

  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mult_done && (mult_rd_q != 5'd0) && (mult_rd_q == ex_rs[5*i +: 5]))
        fwd_sel[2*i +: 2] = 2'b11;
      else if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == ex_rs[5*i +: 5]))
        fwd_sel[2*i +: 2] = 2'b10;
      else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == ex_rs[5*i +: 5]))
        fwd_sel[2*i +: 2] = 2'b01;
    end
  end

  // On the last busy cycle the product is bypassed, so only cnt > 1 blocks dependents.
  always_comb begin
    stall = id_is_mult && mult_long;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i]) begin
        if (ex_memread && (ex_rd != 5'd0) && (ex_rd == id_rs[5*i +: 5]))
          stall = 1'b1;
        if (mult_long && (mult_rd_q != 5'd0) && (mult_rd_q == id_rs[5*i +: 5]))
          stall = 1'b1;
        if (ex_mult_issue && (ex_rd != 5'd0) && (ex_rd == id_rs[5*i +: 5]))
          stall = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q       <= '0;
      mult_rd_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mult_rd_q   <= mult_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit (NUM_SRC=2, MULT_LAT=3, CNT_W=4).
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic        id_is_mult;
  logic [9:0]  ex_rs;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic        ex_mult_issue;
  logic [4:0]  exmem_rd;
  logic        exmem_regwrite;
  logic [4:0]  memwb_rd;
  logic        memwb_regwrite;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic        mult_busy;
  logic        mult_done;
  logic [4:0]  mult_rd;
  logic [3:0]  stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_forward_unit #(.NUM_SRC(2), .MULT_LAT(3), .CNT_W(4)) dut (
    .clk(clk), .arst_n(arst_n),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_is_mult(id_is_mult),
    .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_mult_issue(ex_mult_issue),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .fwd_sel(fwd_sel), .stall(stall), .mult_busy(mult_busy), .mult_done(mult_done),
    .mult_rd(mult_rd), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rs_used = '0; id_is_mult = 0;
    ex_rs = '0; ex_rd = '0; ex_memread = 0; ex_mult_issue = 0;
    exmem_rd = '0; exmem_regwrite = 0; memwb_rd = '0; memwb_regwrite = 0;
  endtask

  // Inputs change 1 unit after a rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    #1;
  endtask

  initial begin
    clear_inputs();
    arst_n = 1'b0;
    #2;
    chk("rst_busy", mult_busy, 0);
    chk("rst_done", mult_done, 0);
    chk("rst_rd", mult_rd, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fwd", fwd_sel, 0);
    do_reset();

    // Forwarding priority
    exmem_rd = 5; exmem_regwrite = 1; memwb_rd = 5; memwb_regwrite = 1; ex_rs = {5'd0, 5'd5};
    #1; chk("fwd_exmem", fwd_sel, 4'b0010);
    exmem_regwrite = 0;
    #1; chk("fwd_memwb", fwd_sel, 4'b0001);
    exmem_regwrite = 1; exmem_rd = 6; ex_rs = {5'd6, 5'd5};
    #1; chk("fwd_both", fwd_sel, 4'b1001);
    exmem_rd = 0; memwb_rd = 0; ex_rs = '0;
    #1; chk("fwd_x0", fwd_sel, 4'b0000);
    clear_inputs();

    // Load-use
    ex_memread = 1; ex_rd = 7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    #1; chk("lu_stall", stall, 1);
    tick();
    chk("lu_cnt", stall_cnt, 1);
    ex_memread = 0;
    #1; chk("lu_bubble", stall, 0);
    ex_memread = 1; id_rs_used = 2'b01;
    #1; chk("lu_unused", stall, 0);
    ex_rd = 0; id_rs = '0; id_rs_used = 2'b11;
    #1; chk("lu_x0", stall, 0);

    // Multiply RAW
    do_reset();
    ex_mult_issue = 1; ex_rd = 9; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    #1; chk("mr_c0_stall", stall, 1);
    chk("mr_c0_busy", mult_busy, 0);
    tick();
    ex_mult_issue = 0; ex_rd = 0;
    #1; chk("mr_c1_stall", stall, 1);
    chk("mr_c1_busy", mult_busy, 1);
    chk("mr_c1_rd", mult_rd, 9);
    chk("mr_c1_done", mult_done, 0);
    tick();
    chk("mr_c2_stall", stall, 1);
    chk("mr_c2_done", mult_done, 0);
    tick();
    ex_rs = {5'd0, 5'd9};
    #1; chk("mr_c3_done", mult_done, 1);
    chk("mr_c3_stall", stall, 0);
    chk("mr_c3_fwd", fwd_sel, 4'b0011);
    chk("mr_c3_cnt", stall_cnt, 3);
    tick();
    chk("mr_c4_busy", mult_busy, 0);
    chk("mr_c4_fwd", fwd_sel, 4'b0000);

    // Structural hazard and back-to-back reissue
    do_reset();
    ex_mult_issue = 1; ex_rd = 4;
    tick();
    ex_mult_issue = 0;
    tick();
    id_is_mult = 1;
    #1; chk("st_cnt2", stall, 1);
    tick();
    chk("st_cnt1", stall, 0);
    chk("st_done1", mult_done, 1);
    ex_mult_issue = 1; ex_rd = 12;
    tick();
    ex_mult_issue = 0; id_is_mult = 0;
    #1; chk("st_re_busy", mult_busy, 1);
    chk("st_re_rd", mult_rd, 12);
    chk("st_re_done", mult_done, 0);
    tick();
    chk("st_re_c2", mult_done, 0);
    tick();
    chk("st_re_c1", mult_done, 1);

    // Reset mid-multiply
    do_reset();
    ex_mult_issue = 1; ex_rd = 3;
    tick();
    ex_mult_issue = 0; id_is_mult = 1;
    tick();
    chk("rm_cnt_pre", stall_cnt, 1);
    arst_n = 0;
    #1; chk("rm_busy", mult_busy, 0);
    chk("rm_cnt", stall_cnt, 0);
    id_is_mult = 0;
    tick();
    arst_n = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rm_no_done", mult_done, 0);
    end

    // Saturation
    do_reset();
    ex_memread = 1; ex_rd = 3; id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
    for (int k = 0; k < 14; k++) tick();
    chk("sat_14", stall_cnt, 14);
    tick();
    chk("sat_15", stall_cnt, 15);
    for (int k = 0; k < 5; k++) tick();
    chk("sat_hold", stall_cnt, 15);
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised forwarding and hazard-control unit for the 5-stage RISC-V pipeline with a multi-cycle multiplier.
- Computes operand-bypass selects for NUM_SRC source operands in EX.
- Detects load-use and multiplier RAW hazards in ID.
- Tracks the in-flight multiply with a latency counter, stalls the front end, and keeps a saturating stall-cycle counter for performance readout.

Parameters:
NUM_SRC, 2, number of source-register operands checked (rs1, rs2, ...; operand i uses bits [5i+4:5i])
MULT_LAT, 3, multiplier latency in cycles (>=2); result valid on the last busy cycle
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock, rising edge
arst_n  in  1  asynchronous active-low reset
id_rs  in  5*NUM_SRC  source register indices of the instruction in ID
id_rs_used  in  NUM_SRC  per-operand flag: operand i is actually read
id_is_mult  in  1  instruction in ID is a multiply
ex_rs  in  5*NUM_SRC  source register indices of the instruction in EX
ex_rd  in  5  destination register of the instruction in EX
ex_memread  in  1  instruction in EX is a load
ex_mult_issue  in  1  multiply enters the multiplier this cycle
exmem_rd  in  5  EX/MEM destination register
exmem_regwrite  in  1  EX/MEM writes the register file
memwb_rd  in  5  MEM/WB destination register
memwb_regwrite  in  1  MEM/WB writes the register file
fwd_sel  out  2*NUM_SRC  per-operand mux select: 00 RF/ID_EX, 01 MEM/WB, 10 EX/MEM, 11 multiplier result
stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
mult_busy  out  1  multiplier occupied
mult_done  out  1  one-cycle pulse; multiplier result valid, write back mult_rd
mult_rd  out  5  destination register of the in-flight multiply
stall_cnt  out  CNT_W  total stall cycles since reset, saturating

Behaviour:
- Reset (arst_n low, asynchronous): mult counter = 0, mult_rd = 0, stall_cnt = 0.
  - Consequently mult_busy = 0, mult_done = 0, and stall/fwd_sel depend only on the combinational terms below.
  - Reset asserted mid-multiply abandons it: no mult_done pulse.
- Multiply counter cnt (width clog2(MULT_LAT+1)):
  - On ex_mult_issue with cnt == 0: cnt <= MULT_LAT, mult_rd <= ex_rd.
  - Otherwise, if cnt != 0: cnt <= cnt - 1.
  - mult_busy = (cnt != 0); mult_done = (cnt == 1).
  - ex_mult_issue while cnt > 1 cannot occur (prevented by stall). If it occurs at cnt == 1, the new multiply is accepted back-to-back: cnt reloads and mult_rd updates.
- Forwarding, per operand i, with r = ex_rs[i], combinational, priority order:
  1. 11 if mult_done && mult_rd != 0 && mult_rd == r.
  2. 10 if exmem_regwrite && exmem_rd != 0 && exmem_rd == r.
  3. 01 if memwb_regwrite && memwb_rd != 0 && memwb_rd == r.
  4. 00 otherwise.
  - x0 never forwards.
- Stall, combinational. OR of the following, considering only operands with id_rs_used[i] set:
  - Load-use: ex_memread && ex_rd != 0 && ex_rd == id_rs[i]. Exactly one stall cycle per load.
  - Multiply RAW: cnt > 1 && mult_rd != 0 && mult_rd == id_rs[i]. At cnt == 1 the value is forwarded with 11, so no stall.
  - Multiply structural: id_is_mult && cnt > 1.
  - Multiply in EX this cycle: ex_mult_issue && ex_rd != 0 && ex_rd == id_rs[i]. The dependent instruction waits for the counter.
  - Simultaneous conditions give a single stall; no extra cycles.
- stall_cnt increments by 1 on every clock edge where stall = 1 and arst_n = 1. It holds at 2^CNT_W - 1.
- Any fwd_sel source match with an operand whose id_rs_used bit is 0 still forwards, which is harmless. Stalls require the used bit.

Test Plan:
- Back-to-back ALU dependency: exmem_rd=5, exmem_regwrite=1, memwb_rd=5, memwb_regwrite=1, ex_rs[0]=5 -> fwd_sel[1:0]=10; clear exmem_regwrite -> 01; ex_rs[0]=0 with all rd=0 -> 00.
- Load-use: ex_memread=1, ex_rd=7, id_rs[1]=7, id_rs_used=2'b10 -> stall=1 for one cycle, stall_cnt 0->1; same with id_rs_used=2'b01 -> stall=0.
- Multiply RAW, MULT_LAT=3:
  - Cycle 0: ex_mult_issue=1, ex_rd=9, id_rs[0]=9 -> stall=1.
  - Cycle 1 (cnt=3) and cycle 2 (cnt=2): stall=1, mult_busy=1.
  - Cycle 3: cnt=1, mult_done=1, stall=0, and fwd_sel[1:0]=11 once the consumer reaches EX with ex_rs[0]=9.
- Structural: id_is_mult=1 while cnt=2 -> stall=1; at cnt=1 -> stall=0, and a re-issue reloads cnt=3 with the new mult_rd.
- Reset mid-multiply: drop arst_n at cnt=2 -> mult_busy=0, stall_cnt=0 immediately; no mult_done after release.
- Saturation: CNT_W=4, hold stall for 20 cycles -> stall_cnt=15 and stays at 15.
